// File: rtl/rf_wb_ctrl_pkg.sv
// rf_wb_ctrl_pkg: shared CPU register-file constants and helpers
package rf_wb_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// rf_wb_ctrl_if: pipeline, long-unit, issue and register-file write signals
interface rf_wb_ctrl_if
    import rf_wb_ctrl_pkg::*;
#(
    parameter int DW = XLEN
);
    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DW-1:0]         wb_data;
    logic                  lu_valid;
    logic                  lu_ready;
    logic [REG_ADDR_W-1:0] lu_rd;
    logic [DW-1:0]         lu_data;
    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rd;
    logic [NUM_REGS-1:0]   busy;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] wR;
    logic [DW-1:0]         wD;

    modport master (
        output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data, iss_valid, iss_rd,
        input  wb_ready, lu_ready, busy, rf_we, wR, wD
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data, iss_valid, iss_rd,
        output wb_ready, lu_ready, busy, rf_we, wR, wD
    );
endinterface

// File: rtl/rf_wb_ctrl_wb_fifo.sv
// wb_fifo: small synchronous FIFO holding long-unit results until they win the write port
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wp_d  = do_push ? wp_q + AW'(1) : wp_q;
        rp_d  = do_pop ? rp_q + AW'(1) : rp_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Occupancy state; reset discards all contents
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset since occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: arbitrates pipeline and long-unit writebacks onto the register-file write port
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter int DW         = XLEN,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic         cpu_clk,
    input logic         cpu_rst,
    rf_wb_ctrl_if.slave bus
);
    localparam int EW = DW + REG_ADDR_W;
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [EW-1:0]         head;
    logic                  full, empty, pipe_gnt, fifo_gnt;
    logic [REG_ADDR_W-1:0] head_rd, sel_rd;
    logic [DW-1:0]         head_data, sel_data;
    logic [CW-1:0]         starve_q, starve_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wr_q, wr_d;
    logic [DW-1:0]         wd_q, wd_d;

    assign head_rd      = head[EW-1 -: REG_ADDR_W];
    assign head_data    = head[DW-1:0];
    assign bus.lu_ready = !full;
    assign bus.wb_ready = !(full && starve_q == CW'(STARVE_MAX));
    assign bus.busy     = busy_q;
    assign bus.rf_we    = we_q;
    assign bus.wR       = wr_q;
    assign bus.wD       = wd_q;

    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk_i  (cpu_clk),
        .rst_i  (cpu_rst),
        .push_i (bus.lu_valid),
        .pop_i  (fifo_gnt),
        .din_i  ({bus.lu_rd, bus.lu_data}),
        .full_o (full),
        .empty_o(empty),
        .head_o (head)
    );

    // Pipeline wins unless held for starvation; rd==0 grants consume without writing
    always_comb begin
        pipe_gnt = bus.wb_valid && bus.wb_ready;
        fifo_gnt = !pipe_gnt && !empty;
        sel_rd   = pipe_gnt ? bus.wb_rd : head_rd;
        sel_data = pipe_gnt ? bus.wb_data : head_data;
        we_d     = (pipe_gnt || fifo_gnt) && sel_rd != '0;
        wr_d     = we_d ? sel_rd : wr_q;
        wd_d     = we_d ? sel_data : wd_q;
        starve_d = (fifo_gnt || !full) ? '0 : pipe_gnt ? starve_q + CW'(1) : starve_q;
        busy_d   = (busy_q & ~(fifo_gnt ? reg_bit(head_rd) : '0))
                 | (bus.iss_valid ? reg_bit(bus.iss_rd) : '0);
        busy_d[0] = 1'b0;
    end

    // Registered write port, scoreboard and starvation counter
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            starve_q <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            wr_q     <= '0;
            wd_q     <= '0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            wr_q     <= wr_d;
            wd_q     <= wd_d;
        end
    end
endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Writeback controller that owns the write port of the CPU register file (drives `rf_we`/`wR`/`wD`). Merges single-cycle writebacks from the main pipeline with out-of-order results from a long-latency unit (load/mul-div), buffers the latter in a small FIFO, and arbitrates one register write per cycle. Also keeps a busy scoreboard of registers with outstanding long-latency results for the hazard/stall logic.

## Interface
- `DW`, 32: data width
- `DEPTH`, 2: long-unit result FIFO entries (power of 2, ≥2)
- `STARVE_MAX`, 4: consecutive pipeline wins with a full FIFO before the pipeline is held
---
- Clock and reset: one clock; reset is asynchronous and active-high.
- `cpu_clk` in 1: clock
- `cpu_rst` in 1: reset
- `wb_valid` in 1: pipeline writeback request
- `wb_ready` out 1: pipeline writeback accepted this cycle
- `wb_rd` in 5: pipeline destination
- `wb_data` in DW: pipeline result
- `lu_valid` in 1: long-unit result valid
- `lu_ready` out 1: FIFO can accept
- `lu_rd` in 5: long-unit destination
- `lu_data` in DW: long-unit result
- `iss_valid` in 1: long-latency instruction issued
- `iss_rd` in 5: its destination
- `busy` out 32: scoreboard, bit n = xn has a pending long-unit result
- `rf_we` out 1: RF write enable
- `wR` out 5: RF write address
- `wD` out DW: RF write data

## Operation
- Long unit: push on `lu_valid && lu_ready`; `lu_ready = !full`, where full is evaluated at cycle start. No push-while-full even if a pop occurs in the same cycle.
- Arbiter, evaluated each cycle:
  - Pipeline has priority: if `wb_valid && wb_ready`, the pipeline is granted.
  - Otherwise, if the FIFO is non-empty, the FIFO head is granted and popped.
- Starvation:
  - `starve_cnt` increments when the FIFO is full and the pipeline is granted.
  - It clears on any FIFO pop or whenever the FIFO is not full.
  - `wb_ready = !(full && starve_cnt == STARVE_MAX)`.
  - When `wb_ready` is 0, the pipeline holds its request and the FIFO head is granted.
- x0:
  - A granted entry with rd == 0 is consumed (FIFO popped, pipeline accepted) but `rf_we` stays 0.
  - `iss_rd == 0` never sets `busy`.
- Scoreboard:
  - Set `busy[iss_rd]` on `iss_valid`.
  - Clear `busy[rd]` when a FIFO entry is granted.
  - If set and clear hit the same rd in the same cycle, set wins.
  - Pipeline writes never touch `busy`. Stall logic must prevent a pipeline write to a busy register; if one occurs anyway, the write is still performed.
- `busy[0]` is always 0.

## Timing
- Reset:
  - `rf_we` = 0, `wR` = 0, `wD` = 0, `busy` = 0.
  - FIFO empty and `starve_cnt` = 0.
  - `lu_ready` = 1, `wb_ready` = 1.
  - Reset mid-operation discards all FIFO contents and clears the scoreboard.
- `rf_we`/`wR`/`wD` are registered: a grant in cycle N produces the RF write at the edge ending cycle N+1, so the value is readable from cycle N+2.
- `busy` is registered and updates the cycle after `iss_valid` or a grant.
- `wb_ready` and `lu_ready` are combinational from registered state only; neither depends on the valid inputs.
- Pointers wrap modulo DEPTH. The count is held in log2(DEPTH)+1 bits.
- No grant in a cycle → `rf_we` = 0 next cycle. `wR`/`wD` hold their last value.

## Structure
- Shared CPU package holds `REG_ADDR_W` = 5, `NUM_REGS` = 32, and `XLEN` (default for DW).
- Sub-module `wb_fifo`: synchronous FIFO parameterized by DW+5 and DEPTH, with push, pop, full, empty, and head outputs.
- Arbiter, starvation counter, scoreboard and output registers live in the top module.

## Test plan
- Reset → all outputs 0, `lu_ready` = `wb_ready` = 1. Assert reset while the FIFO holds 2 entries → FIFO empty, `busy` = 0, no write.
- `wb_valid`, rd = 5, data = 0x1234 in cycle N → `rf_we` = 1, `wR` = 5, `wD` = 0x1234 in cycle N+1. Repeat with rd = 0 → `rf_we` stays 0.
- `iss_valid`, rd = 7 → `busy[7]` = 1. Later `lu_valid`, rd = 7, data = 0xBEEF with pipeline idle → RF write of 0xBEEF to x7, and `busy[7]` clears the cycle after the grant.
- FIFO full (2 entries) with `wb_valid` held every cycle → 4 pipeline grants, then `wb_ready` = 0 for one cycle and the FIFO head is written. `lu_ready` stays 0 until the pop.
- Same-cycle `iss_valid` rd = 3 and FIFO grant rd = 3 → `busy[3]` remains 1.
- Simultaneous pipeline rd = 9 and long-unit rd = 10 in cycle N (FIFO empty) → x9 written at N+1, x10 written at N+2.
